exec_controller: RTL and testbench
==================================

# exec_controller

Run-control sequencer for the MiniAlu core. It owns the core's clock-enable and synchronous reset, and provides host run, halt and single-step commands. It adds an instruction-pointer breakpoint and an enabled-cycle counter. It sits between the host/debug logic and the core: it observes the core's instruction pointer and gates the instruction-pointer counter and pipeline flip-flop enables.

## Interface
Parameters:
- IP_WIDTH, 16, width of the instruction pointer.
- CNT_WIDTH, 32, width of the enabled-cycle counter.
- RESET_CYCLES, 2, number of cycles oCoreReset is held after leaving reset (≥1).
- WDOG_CYCLES, 16, stuck-IP threshold used by the watchdog (≥2).

Ports:
- Clock  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  reset, asynchronous and active-low.
- iRun  in  1  one-cycle pulse: start free-running.
- iHalt  in  1  one-cycle pulse: stop the core.
- iStep  in  1  one-cycle pulse: execute exactly one enabled cycle.
- iClearCount  in  1  synchronous clear of oCycleCount.
- iBreakEn  in  1  breakpoint enable.
- iBreakAddr  in  IP_WIDTH  breakpoint address.
- iIP  in  IP_WIDTH  current core instruction pointer.
- oCoreReset  out  1  active-high synchronous reset to the core.
- oCoreEnable  out  1  core enable.
- oState  out  2  state: 0 INIT, 1 HALTED, 2 RUN, 3 STEP.
- oHaltCause  out  2  cause of the last halt: 0 none/step, 1 host, 2 breakpoint, 3 loop.
- oCycleCount  out  CNT_WIDTH  number of cycles with oCoreEnable=1.

## Operation
- **INIT**
  - oCoreReset=1 and oCoreEnable=0 for RESET_CYCLES cycles; a down-counter times this.
  - Then go to HALTED.
  - All commands are ignored in INIT.
- **HALTED**
  - oCoreEnable=0.
  - Command priority when pulses coincide: iHalt > iStep > iRun.
  - iHalt: no state change. iStep: go to STEP. iRun: go to RUN.
- **STEP**
  - oCoreEnable=1 for exactly one cycle.
  - Then go to HALTED and set oHaltCause=0.
- **RUN**
  - oCoreEnable = RUN && !brk_hit.
  - brk_hit = iBreakEn && armed && (iIP == iBreakAddr).
  - On brk_hit: go to HALTED with cause 2. The core is frozen in the hit cycle, so the instruction at iBreakAddr is not fetched.
  - iHalt: go to HALTED with cause 1. Effective from the next cycle, so one more enabled cycle occurs.
  - iStep in RUN is ignored.
- **armed flag**
  - Cleared on every transition into RUN or STEP.
  - Set after the first enabled cycle.
  - Purpose: resuming from a breakpoint does not re-trigger on the same IP.
- **oCycleCount**
  - Increments on every cycle with oCoreEnable=1.
  - Saturates at all-ones and does not wrap.
  - iClearCount has priority over increment, so the counter reads 0 on the next cycle.
- oHaltCause holds its value until the next halt event.

## Timing
- **Reset assertion**
  - Immediate and asynchronous.
  - Outputs: state INIT, oCoreReset=1, oCoreEnable=0, oHaltCause=0, oCycleCount=0, armed=0.
- **Reset release:** oCoreReset stays high for exactly RESET_CYCLES rising edges, then oState=1.
- **Registered outputs:** oState, oCoreReset, oHaltCause, oCycleCount.
- **Combinational output:** oCoreEnable, from state, brk_hit and iIP.
- **Command latency:** a command pulse sampled at edge N changes oState after edge N. For iRun, oCoreEnable=1 in cycle N+1.
- **Reset mid-operation:** Reset asserted while in RUN or STEP forces INIT immediately and the counter clears.
- **Breakpoint boundary:** breakpoint while iBreakEn toggles in the same cycle; only the current-cycle value counts.

## Configuration
- **EXEC_CTRL_WATCHDOG_EN defined**
  - In RUN, a stuck-IP counter tracks enabled cycles where iIP equals its value from the previous enabled cycle; any change clears it.
  - When the counter reaches WDOG_CYCLES, go to HALTED with cause 3. This catches the "JMP self" end-of-program idiom.
  - The stuck-IP counter clears on entering RUN.
- **EXEC_CTRL_WATCHDOG_EN undefined:** no watchdog logic is built, cause 3 is never produced, and RUN continues indefinitely on a stuck IP.

## Test plan
- **Reset sequence:** assert Reset low, release -> oCoreReset=1 for 2 cycles, then oState=1, oCoreEnable=0, oCycleCount=0.
- **Single step:** in HALTED, pulse iStep -> oCoreEnable=1 for exactly one cycle, oState returns to 1, oHaltCause=0, oCycleCount=1. Pulse iStep and iRun together -> STEP taken.
- **Breakpoint:** iBreakEn=1, iBreakAddr=5, iRun, core IP counts 0,1,2... -> oCoreEnable=0 in the cycle iIP=5, oState=1, oHaltCause=2, oCycleCount=5. iRun again -> execution passes IP 5 without re-halting.
- **Host halt and saturation:** force oCycleCount near all-ones (CNT_WIDTH=4 build), run -> counter stops at 15. iHalt -> HALTED, cause 1. iClearCount -> 0.
- **Watchdog:** with EXEC_CTRL_WATCHDOG_EN, WDOG_CYCLES=16, iIP held at 7 in RUN -> HALTED with cause 3 after 16 enabled cycles. Without the macro -> stays in RUN.
- **Reset mid-run:** drop Reset during RUN -> oState=0, oCoreEnable=0 and oCycleCount=0 in the same cycle, before the next edge.

Source files
------------

// File: rtl/exec_controller.sv
// Run-control sequencer for the MiniAlu core: reset timing, run/halt/step, IP breakpoint, enabled-cycle counter.
// Optional stuck-IP watchdog is built only when EXEC_CTRL_WATCHDOG_EN is defined.
module exec_controller #(
  parameter int IP_WIDTH     = 16,
  parameter int CNT_WIDTH    = 32,
  parameter int RESET_CYCLES = 2,
  parameter int WDOG_CYCLES  = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iRun,
  input  logic                 iHalt,
  input  logic                 iStep,
  input  logic                 iClearCount,
  input  logic                 iBreakEn,
  input  logic [IP_WIDTH-1:0]  iBreakAddr,
  input  logic [IP_WIDTH-1:0]  iIP,
  output logic                 oCoreReset,
  output logic                 oCoreEnable,
  output logic [1:0]           oState,
  output logic [1:0]           oHaltCause,
  output logic [CNT_WIDTH-1:0] oCycleCount
);

  localparam int RST_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_HALTED = 2'd1,
    S_RUN    = 2'd2,
    S_STEP   = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_HOST  = 2'd1;
  localparam logic [1:0] CAUSE_BREAK = 2'd2;
  localparam logic [1:0] CAUSE_LOOP  = 2'd3;

  state_t               state_q, state_d;
  logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic                 core_reset_q, core_reset_d;
  logic [1:0]           cause_q, cause_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 armed_q, armed_d;
  logic                 brk_hit;
  logic                 core_enable;
  logic                 wdog_trip;

  assign brk_hit     = iBreakEn && armed_q && (iIP == iBreakAddr);
  assign core_enable = (state_q == S_STEP) || ((state_q == S_RUN) && !brk_hit);

`ifdef EXEC_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);

  logic [WD_W-1:0]     stuck_cnt_q, stuck_cnt_d;
  logic [IP_WIDTH-1:0] last_ip_q, last_ip_d;

  // Counts the length of the current run of enabled cycles on one IP; outside RUN it stays cleared.
  always_comb begin
    stuck_cnt_d = stuck_cnt_q;
    last_ip_d   = last_ip_q;
    if (state_q != S_RUN) begin
      stuck_cnt_d = '0;
    end else if (core_enable) begin
      last_ip_d = iIP;
      if ((stuck_cnt_q == '0) || (iIP == last_ip_q)) begin
        stuck_cnt_d = stuck_cnt_q + 1'b1;
      end else begin
        stuck_cnt_d = WD_W'(1);
      end
    end
  end

  assign wdog_trip = (state_q == S_RUN) && core_enable && (stuck_cnt_d == WD_W'(WDOG_CYCLES));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      stuck_cnt_q <= '0;
      last_ip_q   <= '0;
    end else begin
      stuck_cnt_q <= stuck_cnt_d;
      last_ip_q   <= last_ip_d;
    end
  end
`else
  assign wdog_trip = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cause_d   = cause_q;
    armed_d   = armed_q;
    cnt_d     = cnt_q;

    unique case (state_q)
      S_INIT: begin
        if (rst_cnt_q <= RST_W'(1)) begin
          state_d = S_HALTED;
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      S_HALTED: begin
        if (iHalt) begin
          state_d = S_HALTED;
        end else if (iStep) begin
          state_d = S_STEP;
        end else if (iRun) begin
          state_d = S_RUN;
        end
      end
      S_STEP: begin
        state_d = S_HALTED;
        cause_d = CAUSE_NONE;
      end
      S_RUN: begin
        // A breakpoint freezes the core this cycle, so it outranks a host halt.
        if (brk_hit) begin
          state_d = S_HALTED;
          cause_d = CAUSE_BREAK;
        end else if (iHalt) begin
          state_d = S_HALTED;
          cause_d = CAUSE_HOST;
        end else if (wdog_trip) begin
          state_d = S_HALTED;
          cause_d = CAUSE_LOOP;
        end
      end
      default: state_d = S_INIT;
    endcase

    // Disarming on entry lets a resume step off the breakpoint address.
    if (((state_d == S_RUN) || (state_d == S_STEP)) && (state_d != state_q)) begin
      armed_d = 1'b0;
    end else if (core_enable) begin
      armed_d = 1'b1;
    end

    if (iClearCount) begin
      cnt_d = '0;
    end else if (core_enable && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end

    core_reset_d = (state_d == S_INIT);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_INIT;
      rst_cnt_q    <= RST_W'(RESET_CYCLES);
      core_reset_q <= 1'b1;
      cause_q      <= CAUSE_NONE;
      cnt_q        <= '0;
      armed_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      core_reset_q <= core_reset_d;
      cause_q      <= cause_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
    end
  end

  assign oCoreReset  = core_reset_q;
  assign oCoreEnable = core_enable;
  assign oState      = state_q;
  assign oHaltCause  = cause_q;
  assign oCycleCount = cnt_q;

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench for exec_controller: vector table for single-cycle behaviour plus
// hand-written sequences for reset, breakpoint with a counting IP, reset mid-run and stuck IP.
module tb_exec_controller;
  localparam int IPW = 16;
  localparam int CW  = 4;

  logic           Clock = 1'b0;
  logic           Reset = 1'b0;
  logic           iRun = 1'b0, iHalt = 1'b0, iStep = 1'b0, iClearCount = 1'b0, iBreakEn = 1'b0;
  logic [IPW-1:0] iBreakAddr = '0;
  logic [IPW-1:0] iIP = '0;
  logic           oCoreReset, oCoreEnable;
  logic [1:0]     oState, oHaltCause;
  logic [CW-1:0]  oCycleCount;

  exec_controller #(
    .IP_WIDTH(IPW), .CNT_WIDTH(CW), .RESET_CYCLES(2), .WDOG_CYCLES(16)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iRun(iRun), .iHalt(iHalt), .iStep(iStep),
    .iClearCount(iClearCount), .iBreakEn(iBreakEn), .iBreakAddr(iBreakAddr), .iIP(iIP),
    .oCoreReset(oCoreReset), .oCoreEnable(oCoreEnable), .oState(oState),
    .oHaltCause(oHaltCause), .oCycleCount(oCycleCount)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic           run, halt, step, clr, be;
    logic [IPW-1:0] addr, ip;
    logic [1:0]     st;     // state after the edge
    logic           en;     // enable before the edge
    logic [1:0]     cause;  // after the edge
    logic [CW-1:0]  cnt;    // after the edge
  } vec_t;

  vec_t tbl[48];
  int   n_vec = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic run, halt, step, clr, be, input int addr, ip,
                     input int st, input logic en, input int cause, cnt);
    tbl[n_vec].run   = run;
    tbl[n_vec].halt  = halt;
    tbl[n_vec].step  = step;
    tbl[n_vec].clr   = clr;
    tbl[n_vec].be    = be;
    tbl[n_vec].addr  = IPW'(addr);
    tbl[n_vec].ip    = IPW'(ip);
    tbl[n_vec].st    = 2'(st);
    tbl[n_vec].en    = en;
    tbl[n_vec].cause = 2'(cause);
    tbl[n_vec].cnt   = CW'(cnt);
    n_vec++;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge Clock);
    iRun = v.run; iHalt = v.halt; iStep = v.step; iClearCount = v.clr;
    iBreakEn = v.be; iBreakAddr = v.addr; iIP = v.ip;
    #1;
    chk($sformatf("v%0d.en", idx), 32'(oCoreEnable), 32'(v.en));
    @(posedge Clock);
    #1;
    chk($sformatf("v%0d.state", idx), 32'(oState), 32'(v.st));
    chk($sformatf("v%0d.cause", idx), 32'(oHaltCause), 32'(v.cause));
    chk($sformatf("v%0d.count", idx), 32'(oCycleCount), 32'(v.cnt));
    $display("vec %0d: run=%0b halt=%0b step=%0b clr=%0b be=%0b ip=%0d -> st=%0d en=%0b cause=%0d cnt=%0d",
             idx, v.run, v.halt, v.step, v.clr, v.be, v.ip, oState, oCoreEnable, oHaltCause, oCycleCount);
    iRun = 0; iHalt = 0; iStep = 0; iClearCount = 0;
  endtask

  // One cycle of a core whose IP advances on every enabled edge.
  task automatic model_cycle(inout int ip);
    logic en_s;
    @(negedge Clock);
    iIP = IPW'(ip);
    #1;
    en_s = oCoreEnable;
    @(posedge Clock);
    #1;
    if (en_s) ip++;
  endtask

  initial begin
    int ip;
    bit done;

    //   run halt step clr be addr ip   st en cause cnt
    add(0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0,   3, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 1);
    add(1, 0, 1, 0, 0, 0, 0,   3, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 2);
    add(1, 1, 1, 0, 0, 0, 0,   1, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 0,   2, 0, 0, 2);
    add(0, 0, 1, 0, 0, 0, 0,   2, 1, 0, 3);
    add(0, 0, 0, 1, 0, 0, 1,   2, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 2,   1, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0, 0,   1, 0, 1, 0);
    add(1, 0, 0, 0, 1, 5, 3,   2, 0, 1, 0);
    add(0, 0, 0, 0, 1, 5, 5,   2, 1, 1, 1);
    add(0, 0, 0, 0, 1, 5, 5,   1, 0, 2, 1);
    add(1, 0, 0, 0, 1, 5, 5,   2, 0, 2, 1);
    add(0, 0, 0, 0, 1, 5, 5,   2, 1, 2, 2);
    add(0, 0, 0, 0, 0, 5, 6,   2, 1, 2, 3);
    add(0, 0, 0, 0, 0, 5, 5,   2, 1, 2, 4);
    add(0, 0, 0, 0, 1, 5, 5,   1, 0, 2, 4);
    add(1, 0, 0, 0, 0, 0, 0,   2, 0, 2, 4);
    for (int k = 5; k <= 15; k++) add(0, 0, 0, 0, 0, 0, 0, 2, 1, 2, k);
    add(0, 0, 0, 0, 0, 0, 0,   2, 1, 2, 15);
    add(0, 1, 0, 0, 0, 0, 0,   1, 1, 1, 15);
    add(0, 0, 0, 1, 0, 0, 0,   1, 0, 1, 0);

    // Reset sequence
    #12;
    chk("rst.state", 32'(oState), 0);
    chk("rst.core_reset", 32'(oCoreReset), 1);
    chk("rst.enable", 32'(oCoreEnable), 0);
    chk("rst.cause", 32'(oHaltCause), 0);
    chk("rst.count", 32'(oCycleCount), 0);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;
    chk("rel1.core_reset", 32'(oCoreReset), 1);
    chk("rel1.state", 32'(oState), 0);
    @(posedge Clock); #1;
    chk("rel2.core_reset", 32'(oCoreReset), 0);
    chk("rel2.state", 32'(oState), 1);
    chk("rel2.enable", 32'(oCoreEnable), 0);
    $display("reset: released, st=%0d core_reset=%0b", oState, oCoreReset);

    for (int i = 0; i < n_vec; i++) apply(tbl[i], i);

    // Breakpoint with a counting core IP
    @(negedge Clock);
    iBreakEn = 1; iBreakAddr = 5; iIP = 0; iRun = 1;
    @(posedge Clock); #1;
    iRun = 0;
    ip = 0;
    done = 0;
    for (int t = 0; t < 20 && !done; t++) begin
      model_cycle(ip);
      if (oState == 2'd1) done = 1;
    end
    chk("bp.reached", 32'(done), 1);
    chk("bp.ip", 32'(ip), 5);
    chk("bp.cause", 32'(oHaltCause), 2);
    chk("bp.count", 32'(oCycleCount), 5);
    $display("bp: halted ip=%0d cause=%0d cnt=%0d", ip, oHaltCause, oCycleCount);

    @(negedge Clock);
    iIP = IPW'(ip); iRun = 1;
    @(posedge Clock); #1;
    iRun = 0;
    for (int t = 0; t < 3; t++) model_cycle(ip);
    chk("resume.ip", 32'(ip), 8);
    chk("resume.state", 32'(oState), 2);
    chk("resume.cause", 32'(oHaltCause), 2);
    $display("resume: ip=%0d st=%0d", ip, oState);

    // Reset mid-run
    @(posedge Clock); #3;
    Reset = 1'b0;
    #1;
    chk("midrst.state", 32'(oState), 0);
    chk("midrst.enable", 32'(oCoreEnable), 0);
    chk("midrst.count", 32'(oCycleCount), 0);
    chk("midrst.core_reset", 32'(oCoreReset), 1);
    chk("midrst.cause", 32'(oHaltCause), 0);
    $display("midrst: st=%0d en=%0b cnt=%0d", oState, oCoreEnable, oCycleCount);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    chk("midrst.rel_state", 32'(oState), 1);

    // Stuck IP ("JMP self")
    @(negedge Clock);
    iBreakEn = 0; iIP = 7; iRun = 1;
    @(posedge Clock); #1;
    iRun = 0;
    repeat (20) @(posedge Clock);
    #1;
`ifdef EXEC_CTRL_WATCHDOG_EN
    chk("stuck.state", 32'(oState), 1);
    chk("stuck.cause", 32'(oHaltCause), 3);
`else
    chk("stuck.state", 32'(oState), 2);
    chk("stuck.cause", 32'(oHaltCause), 0);
`endif
    chk("stuck.count", 32'(oCycleCount), 15);
    $display("stuck: st=%0d cause=%0d cnt=%0d", oState, oHaltCause, oCycleCount);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
